// File: rtl/sr_bank_driver.sv
// sr_bank_driver: turns requested target values into S/R pulses for a bank of SR flops.
// Optional readback check enabled by defining SR_BANK_DRIVER_VERIFY_EN.
module sr_bank_driver #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned PULSE_CYC = 1,
   parameter int unsigned GAP_CYC   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic [WIDTH-1:0] req_data,
   output logic             req_ready,
   output logic [WIDTH-1:0] s_out,
   output logic [WIDTH-1:0] r_out,
   output logic [WIDTH-1:0] shadow_q,
   output logic             busy,
   input  logic [WIDTH-1:0] q_in,
   input  logic             err_clr,
   output logic             mismatch
);

   localparam int unsigned CMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
   localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYC - 1);
   localparam logic [CW-1:0] GAP_LOAD   = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      GAP
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] target, target_nxt;
   logic [WIDTH-1:0] s_nxt, r_nxt, shadow_nxt;
   logic [WIDTH-1:0] set_m, clr_m;
   logic             drive_exit;

   // Only bits that actually differ from the shadow get a pulse, so S and R never overlap.
   assign set_m = req_data & ~shadow_q;
   assign clr_m = ~req_data & shadow_q;

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         target   <= '0;
         s_out    <= '0;
         r_out    <= '0;
         shadow_q <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         target   <= target_nxt;
         s_out    <= s_nxt;
         r_out    <= r_nxt;
         shadow_q <= shadow_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      target_nxt = target;
      s_nxt      = s_out;
      r_nxt      = r_out;
      shadow_nxt = shadow_q;
      drive_exit = 1'b0;
      case (state)
         IDLE: begin
            s_nxt = '0;
            r_nxt = '0;
            if (req_valid && ((set_m | clr_m) != '0)) begin
               s_nxt      = set_m;
               r_nxt      = clr_m;
               target_nxt = req_data;
               cnt_nxt    = PULSE_LOAD;
               state_nxt  = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else begin
               s_nxt      = '0;
               r_nxt      = '0;
               shadow_nxt = target;
               drive_exit = 1'b1;
               if (GAP_CYC > 0) begin
                  cnt_nxt   = GAP_LOAD;
                  state_nxt = GAP;
               end else begin
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end
            end
         end
         GAP: begin
            s_nxt = '0;
            r_nxt = '0;
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            s_nxt     = '0;
            r_nxt     = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

`ifdef SR_BANK_DRIVER_VERIFY_EN
   logic check_pend;

   // Compare runs one edge after shadow_q takes the new target, independent of FSM state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         check_pend <= 1'b0;
         mismatch   <= 1'b0;
      end else begin
         check_pend <= drive_exit;
         if (err_clr) begin
            mismatch <= 1'b0;
         end else if (check_pend && (q_in != shadow_q)) begin
            mismatch <= 1'b1;
         end
      end
   end
`else
   logic unused_ok;
   assign unused_ok = ^{q_in, err_clr, drive_exit};
   assign mismatch  = 1'b0;
`endif

endmodule

// File: tb/tb_sr_bank_driver.sv
// Self-checking bench for sr_bank_driver against a transaction-level model of shadow/pulse/mismatch.
// Honours SR_BANK_DRIVER_VERIFY_EN to pick the expected mismatch behaviour.
module tb_sr_bank_driver;

   localparam int unsigned W = 8;
   localparam int unsigned P = 2;
   localparam int unsigned G = 1;
`ifdef SR_BANK_DRIVER_VERIFY_EN
   localparam bit VER = 1'b1;
`else
   localparam bit VER = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst, req_valid, req_ready, busy, err_clr, mismatch;
   logic [W-1:0] req_data, s_out, r_out, shadow_q, q_in, bank, stuck;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int acc_cyc[$];

   logic [W-1:0] model;
   logic         mm_model;

   sr_bank_driver #(.WIDTH(W), .PULSE_CYC(P), .GAP_CYC(G)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .s_out(s_out), .r_out(r_out), .shadow_q(shadow_q),
      .busy(busy), .q_in(q_in), .err_clr(err_clr), .mismatch(mismatch)
   );

   always #5 clk = ~clk;

   // Behavioural SR flop bank; stuck bits read back as 0.
   always @(posedge clk or posedge rst) begin
      if (rst) bank <= '0;
      else     bank <= (bank & ~r_out) | s_out;
   end
   assign q_in = bank & ~stuck;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (req_valid === 1'b1 && req_ready === 1'b1) acc_cyc.push_back(cyc);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic drive_cmd(input logic [W-1:0] d, input string tag);
      logic [W-1:0] es, er;
      logic         mm_next;
      es      = d & ~model;
      er      = ~d & model;
      mm_next = mm_model | (VER && ((d & ~stuck) != d));
      req_valid = 1'b1;
      req_data  = d;
      @(posedge clk); #1;
      if ((es | er) == '0) begin
         tests++;
         if ({s_out, r_out, shadow_q, req_ready, busy, mismatch} !== {8'h00, 8'h00, model, 1'b1, 1'b0, mm_model}) begin
            fails++;
            $display("FAIL %s null: s/r/sh/rdy/busy/mm got %h/%h/%h/%b/%b/%b want 00/00/%h/1/0/%b",
                     tag, s_out, r_out, shadow_q, req_ready, busy, mismatch, model, mm_model);
         end
         req_valid = 1'b0;
         return;
      end
      for (int i = 0; i < P; i++) begin
         req_data = W'($urandom);
         tests++;
         if ({s_out, r_out, shadow_q, req_ready, busy, mismatch} !== {es, er, model, 1'b0, 1'b1, mm_model}) begin
            fails++;
            $display("FAIL %s pulse%0d: s/r/sh/rdy/busy/mm got %h/%h/%h/%b/%b/%b want %h/%h/%h/0/1/%b",
                     tag, i, s_out, r_out, shadow_q, req_ready, busy, mismatch, es, er, model, mm_model);
         end
         tests++;
         if ((s_out & r_out) !== '0) begin
            fails++;
            $display("FAIL %s overlap: s&r got %h want 00", tag, s_out & r_out);
         end
         @(posedge clk); #1;
      end
      model = d;
      for (int i = 0; i < G; i++) begin
         tests++;
         if ({s_out, r_out, shadow_q, req_ready, busy, mismatch} !== {8'h00, 8'h00, model, 1'b0, 1'b1, mm_model}) begin
            fails++;
            $display("FAIL %s gap%0d: s/r/sh/rdy/busy/mm got %h/%h/%h/%b/%b/%b want 00/00/%h/0/1/%b",
                     tag, i, s_out, r_out, shadow_q, req_ready, busy, mismatch, model, mm_model);
         end
         @(posedge clk); #1;
      end
      mm_model = mm_next;
      tests++;
      if ({s_out, r_out, shadow_q, req_ready, busy, mismatch} !== {8'h00, 8'h00, model, 1'b1, 1'b0, mm_model}) begin
         fails++;
         $display("FAIL %s done: s/r/sh/rdy/busy/mm got %h/%h/%h/%b/%b/%b want 00/00/%h/1/0/%b",
                  tag, s_out, r_out, shadow_q, req_ready, busy, mismatch, model, mm_model);
      end
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      req_valid = 1'b1;
      req_data  = 8'h5A;
      @(posedge clk); #1;
      req_valid = 1'b0;
      tests++;
      if (s_out !== 8'h5A) begin
         fails++;
         $display("FAIL reset_pre: s_out got %h want 5a", s_out);
      end
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({s_out, r_out, shadow_q, req_ready, busy, mismatch} !== {8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset_async: s/r/sh/rdy/busy/mm got %h/%h/%h/%b/%b/%b want 00/00/00/1/0/0",
                  s_out, r_out, shadow_q, req_ready, busy, mismatch);
      end
      @(posedge clk); #3;
      rst = 1'b0;
      @(posedge clk); #1;
      model    = '0;
      mm_model = 1'b0;
   endtask

   task automatic test_set_pattern();
      drive_cmd(8'hA5, "set_pattern");
   endtask

   task automatic test_mixed();
      drive_cmd(8'h3C, "mixed");
   endtask

   task automatic test_null();
      drive_cmd(8'h3C, "null");
      drive_cmd(8'h3C, "null2");
      drive_cmd(8'h00, "after_null");
      drive_cmd(8'h3C, "restore");
   endtask

   task automatic test_abort();
      req_valid = 1'b1;
      req_data  = 8'hFF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      tests++;
      if ({s_out, r_out} !== {8'hC3, 8'h00}) begin
         fails++;
         $display("FAIL abort_drive: s/r got %h/%h want c3/00", s_out, r_out);
      end
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({s_out, r_out, shadow_q, req_ready, busy} !== {8'h00, 8'h00, 8'h00, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL abort_async: s/r/sh/rdy/busy got %h/%h/%h/%b/%b want 00/00/00/1/0",
                  s_out, r_out, shadow_q, req_ready, busy);
      end
      @(posedge clk); #2;
      rst = 1'b0;
      model    = '0;
      mm_model = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         tests++;
         if ({s_out, r_out, shadow_q, req_ready, busy, mismatch} !== {8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL abort_idle%0d: s/r/sh/rdy/busy/mm got %h/%h/%h/%b/%b/%b want 00/00/00/1/0/0",
                     i, s_out, r_out, shadow_q, req_ready, busy, mismatch);
         end
      end
   endtask

   task automatic test_verify();
      stuck = 8'h08;
      drive_cmd(8'h08, "verify");
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         tests++;
         if (mismatch !== mm_model) begin
            fails++;
            $display("FAIL verify_hold%0d: mismatch got %b want %b", i, mismatch, mm_model);
         end
      end
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr  = 1'b0;
      mm_model = 1'b0;
      tests++;
      if (mismatch !== 1'b0) begin
         fails++;
         $display("FAIL verify_clr: mismatch got %b want 0", mismatch);
      end
      stuck = '0;
   endtask

   task automatic test_random();
      logic [W-1:0] d;
      int           idle;
      for (int n = 0; n < 40; n++) begin
         d = ($urandom_range(0, 3) == 0) ? model : W'($urandom);
         drive_cmd(d, "random");
         idle = $urandom_range(0, 2);
         for (int i = 0; i < idle; i++) begin
            req_data = W'($urandom);
            @(posedge clk); #1;
            tests++;
            if ({s_out, r_out, shadow_q, req_ready, busy, mismatch} !== {8'h00, 8'h00, model, 1'b1, 1'b0, mm_model}) begin
               fails++;
               $display("FAIL random_idle: s/r/sh/rdy/busy/mm got %h/%h/%h/%b/%b/%b want 00/00/%h/1/0/%b",
                        s_out, r_out, shadow_q, req_ready, busy, mismatch, model, mm_model);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] d;
      acc_cyc.delete();
      for (int n = 0; n < 6; n++) begin
         d = model ^ W'($urandom_range(1, 255));
         drive_cmd(d, "b2b");
      end
      tests++;
      if (acc_cyc.size() != 6) begin
         fails++;
         $display("FAIL b2b_count: accepts got %0d want 6", acc_cyc.size());
      end else begin
         for (int i = 1; i < 6; i++) begin
            tests++;
            if (acc_cyc[i] - acc_cyc[i-1] != int'(P + G + 1)) begin
               fails++;
               $display("FAIL b2b_spacing%0d: got %0d want %0d", i, acc_cyc[i] - acc_cyc[i-1], P + G + 1);
            end
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_data  = '0;
      err_clr   = 1'b0;
      stuck     = '0;
      model     = '0;
      mm_model  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_set_pattern();
      test_mixed();
      test_null();
      test_abort();
      test_verify();
      test_random();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
